pipe_skid_reg: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, a one-entry skid buffer and a synchronous flush. It is the successor to the plain enable flip-flop used between npc pipeline stages (IF/ID/EX/MEM/WB). It adds back-pressure, full throughput and squash on redirect. Its `in_ready` output is fully registered, so no combinational path from `out_ready` to `in_ready` crosses the stage.

---
 rtl/npc_pipe_defs.sv | 20 ++
 rtl/pipe_data_reg.sv | 24 ++
 rtl/pipe_skid_reg.sv | 117 +++++++++++
 tb/tb_pipe_skid_reg.sv | 136 +++++++++++++
 4 files changed

// File: rtl/npc_pipe_defs.sv
// Shared definitions for npc pipeline stage registers: state encodings for
// debug/trace logic and the default payload width.
package npc_pipe_defs;

    localparam int unsigned PIPE_DATA_LEN = 32;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_BUSY  = 2'd1,
        PIPE_FULL  = 2'd2
    } pipe_state_e;

    // Collapses the two valid bits into a named state; skid without main is unreachable.
    function automatic pipe_state_e pipe_state(input logic main_v, input logic skid_v);
        if (!main_v)     return PIPE_EMPTY;
        else if (skid_v) return PIPE_FULL;
        else             return PIPE_BUSY;
    endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// DATA_LEN-wide enable register with a parametrised reset value; used for the
// main and skid payload slots of pipe_skid_reg.
module pipe_data_reg #(
    parameter int unsigned          DATA_LEN = 32,
    parameter logic [DATA_LEN-1:0]  RST_DATA = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic [DATA_LEN-1:0] d_i,
    output logic [DATA_LEN-1:0] q_o
);

    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    // NOTE: payload is reset too, so out_data is defined before the first beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_o <= RST_DATA;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer
// and synchronous flush; in_ready comes straight from a flop.
module pipe_skid_reg
    import npc_pipe_defs::*;
#(
    parameter int unsigned          DATA_LEN = PIPE_DATA_LEN,
    parameter logic [DATA_LEN-1:0]  RST_DATA = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_LEN-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] out_data
);

    logic                main_v_q, main_v_d;
    logic                skid_v_q, skid_v_d;
    logic                main_load, skid_load, main_from_skid;
    logic [DATA_LEN-1:0] main_data, skid_data, main_src;
    logic                ifire, ofire;
    pipe_state_e         state;

    assign state = pipe_state(main_v_q, skid_v_q);
    assign ifire = in_valid && !skid_v_q;
    assign ofire = main_v_q && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        main_v_d       = main_v_q;
        skid_v_d       = skid_v_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;

        unique case (state)
            PIPE_EMPTY: begin
                skid_v_d = 1'b0;
                if (ifire) begin
                    main_load = 1'b1;
                    main_v_d  = 1'b1;
                end
            end
            PIPE_BUSY: begin
                if (ifire && ofire) begin
                    main_load = 1'b1;
                end else if (ifire) begin
                    skid_load = 1'b1;
                    skid_v_d  = 1'b1;
                end else if (ofire) begin
                    main_v_d  = 1'b0;
                end
            end
            PIPE_FULL: begin
                if (ofire) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_v_d       = 1'b0;
                end
            end
            default: begin
                main_v_d = 1'b0;
                skid_v_d = 1'b0;
            end
        endcase

        // Squash wins over any handshake; the payload slots are left untouched.
        if (flush) begin
            main_v_d  = 1'b0;
            skid_v_d  = 1'b0;
            main_load = 1'b0;
            skid_load = 1'b0;
        end
    end

    assign main_src = main_from_skid ? skid_data : in_data;

    pipe_data_reg #(
        .DATA_LEN (DATA_LEN),
        .RST_DATA (RST_DATA)
    ) u_main_data (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (main_load),
        .d_i   (main_src),
        .q_o   (main_data)
    );

    pipe_data_reg #(
        .DATA_LEN (DATA_LEN),
        .RST_DATA (RST_DATA)
    ) u_skid_data (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (skid_load),
        .d_i   (in_data),
        .q_o   (skid_data)
    );

    assign out_valid = main_v_q;
    assign out_data  = main_data;
    assign in_ready  = !skid_v_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: a reference FIFO of depth two is fed on
// every input handshake and drained on every output handshake.
module tb_pipe_skid_reg;

    localparam int unsigned   W        = 32;
    localparam logic [W-1:0]  RST_DATA = 32'hDEAD_BEEF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;

    logic [W-1:0] sb_q[$];
    int           n_checks = 0;
    int           n_pass = 0;

    pipe_skid_reg #(
        .DATA_LEN (W),
        .RST_DATA (RST_DATA)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Called at a negedge: drive inputs, check outputs against the model,
    // update the model for the coming edge, then advance to the next negedge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        logic ifire, ofire;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        #1;
        check("out_valid", out_valid, sb_q.size() != 0);
        check("in_ready", in_ready, sb_q.size() < 2);
        check("legal_state", dut.skid_v_q & ~dut.main_v_q, 1'b0);
        ifire = v && in_ready;
        ofire = out_valid && r;
        if (f) begin
            sb_q.delete();
        end else begin
            if (ofire && sb_q.size() != 0) check("out_data", out_data, sb_q.pop_front());
            if (ifire) sb_q.push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset
        @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_data", out_data, RST_DATA);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Streaming: 1..8 back to back with downstream always ready
        for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("hold_last", out_data, 32'h8);

        // Stall: A, B fill the stage; C is refused until space frees up
        step(1'b1, 32'hA, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0);
        check("stall_head", out_data, 32'hA);
        step(1'b1, 32'hC, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b1, 1'b0);
        step(1'b1, 32'hC, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("stall_drained", sb_q.size(), 0);

        // Flush while full, with a beat offered in the flush cycle
        step(1'b1, 32'h11, 1'b0, 1'b0);
        step(1'b1, 32'h12, 1'b0, 1'b0);
        step(1'b1, 32'hE, 1'b0, 1'b1);
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Random traffic with occasional flush
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 63) == 0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset while full
        step(1'b1, 32'h21, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_in_ready", in_ready, 1'b1);
        check("arst_out_data", out_data, RST_DATA);
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'h55, 1'b0, 1'b0);
        check("arst_push_data", out_data, 32'h55);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
